// File: rtl/sha256_padder.sv
// sha256_padder
// Byte-stream front end for the SHA-256 compression stage. Message bytes are
// packed big-endian into a 512-bit block buffer. At the end of a message, the
// padder appends 0x80, zero fill and the 64-bit big-endian bit length. When
// the tail does not fit, it emits one extra block. Each block is held on M_out
// until downstream accepts it.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   in_valid     byte-stream valid
//   in_ready     padder can accept a beat (low while rst is high)
//   in_data      message byte
//   in_last      beat ends the message
//   in_empty     with in_last: beat carries no byte, in_data ignored
//   M_out        padded block, byte k at M_out[511-8k -: 8]
//   block_valid  M_out holds a complete block
//   block_ready  downstream consumes the block
//   block_first  block is the first of its message
//   block_last   block is the final padded block of its message
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_empty,
  output logic [511:0] M_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_first,
  output logic         block_last
);

  typedef enum logic [0:0] {
    ST_ABSORB = 1'b0,
    ST_EMIT   = 1'b1
  } state_t;

  // Work still owed after the current block is accepted.
  typedef enum logic [1:0] {
    PEND_NONE   = 2'd0,
    PEND_LEN    = 2'd1,  // length-only block
    PEND_PADLEN = 2'd2   // 0x80 + length block
  } pend_t;

  state_t             r_state;
  pend_t              r_pend;
  logic [6:0]         r_c;
  logic [LEN_W-1:0]   r_bitlen;
  logic               r_first_flag;
  logic [511:0]       r_buf;
  logic               r_block_valid;
  logic               r_block_first;
  logic               r_block_last;

  state_t             w_state;
  pend_t              w_pend;
  logic [6:0]         w_c;
  logic [LEN_W-1:0]   w_bitlen;
  logic               w_first_flag;
  logic [511:0]       w_buf;
  logic               w_block_valid;
  logic               w_block_first;
  logic               w_block_last;

  logic               w_accept;
  logic               w_has_byte;
  logic [6:0]         w_n;
  logic [8:0]         w_byte_base;
  logic [8:0]         w_pad_base;
  logic [LEN_W-1:0]   w_bitlen_inc;

  // in_ready depends on rst so that it reads low during the reset cycle itself.
  assign in_ready    = (r_state == ST_ABSORB) & ~rst;
  assign w_accept    = in_valid & in_ready;

  assign M_out       = r_buf;
  assign block_valid = r_block_valid;
  assign block_first = r_block_first;
  assign block_last  = r_block_last;

  // Next-state and datapath update for the absorb/emit sequencer.
  always_comb begin
    w_state       = r_state;
    w_pend        = r_pend;
    w_c           = r_c;
    w_bitlen      = r_bitlen;
    w_first_flag  = r_first_flag;
    w_buf         = r_buf;
    w_block_valid = r_block_valid;
    w_block_first = r_block_first;
    w_block_last  = r_block_last;

    // An empty beat is only meaningful together with in_last.
    w_has_byte   = ~(in_last & in_empty);
    w_n          = r_c + {6'd0, w_has_byte};
    w_byte_base  = 9'd511 - {r_c[5:0], 3'b000};
    w_pad_base   = 9'd511 - {w_n[5:0], 3'b000};
    w_bitlen_inc = r_bitlen + {{(LEN_W-4){1'b0}}, w_has_byte, 3'b000};

    case (r_state)
      ST_ABSORB: begin
        if (w_accept) begin
          if (w_has_byte) begin
            w_buf[w_byte_base -: 8] = in_data;
          end else begin
            w_buf = r_buf;
          end
          w_c      = w_n;
          w_bitlen = w_bitlen_inc;
          if (in_last) begin
            w_state       = ST_EMIT;
            w_block_valid = 1'b1;
            w_block_first = r_first_flag;
            // The buffer is zero outside the written bytes, so zero fill comes for free.
            if (w_n <= 7'd55) begin
              w_buf[w_pad_base -: 8] = 8'h80;
              w_buf[LEN_W-1:0]       = w_bitlen_inc;
              w_block_last           = 1'b1;
              w_pend                 = PEND_NONE;
            end else if (w_n <= 7'd63) begin
              w_buf[w_pad_base -: 8] = 8'h80;
              w_block_last           = 1'b0;
              w_pend                 = PEND_LEN;
            end else begin
              w_block_last           = 1'b0;
              w_pend                 = PEND_PADLEN;
            end
          end else if (w_n == 7'd64) begin
            w_state       = ST_EMIT;
            w_block_valid = 1'b1;
            w_block_first = r_first_flag;
            w_block_last  = 1'b0;
            w_pend        = PEND_NONE;
          end else begin
            w_state = ST_ABSORB;
          end
        end else begin
          w_state = ST_ABSORB;
        end
      end

      ST_EMIT: begin
        if (block_ready) begin
          w_first_flag = 1'b0;
          case (r_pend)
            PEND_LEN: begin
              w_buf            = 512'd0;
              w_buf[LEN_W-1:0] = r_bitlen;
              w_block_last     = 1'b1;
              w_block_first    = 1'b0;
              w_pend           = PEND_NONE;
            end
            PEND_PADLEN: begin
              w_buf            = {8'h80, 504'd0};
              w_buf[LEN_W-1:0] = r_bitlen;
              w_block_last     = 1'b1;
              w_block_first    = 1'b0;
              w_pend           = PEND_NONE;
            end
            default: begin
              // The final block has been consumed, so the next message starts fresh.
              if (r_block_last) begin
                w_bitlen     = {LEN_W{1'b0}};
                w_first_flag = 1'b1;
              end else begin
                w_bitlen     = r_bitlen;
              end
              w_buf         = 512'd0;
              w_c           = 7'd0;
              w_state       = ST_ABSORB;
              w_block_valid = 1'b0;
              w_block_first = 1'b0;
              w_block_last  = 1'b0;
              w_pend        = PEND_NONE;
            end
          endcase
        end else begin
          w_state = ST_EMIT;
        end
      end

      default: begin
        w_state = ST_ABSORB;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_ABSORB;
      r_pend        <= PEND_NONE;
      r_c           <= 7'd0;
      r_bitlen      <= {LEN_W{1'b0}};
      r_first_flag  <= 1'b1;
      r_buf         <= 512'd0;
      r_block_valid <= 1'b0;
      r_block_first <= 1'b0;
      r_block_last  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_pend        <= w_pend;
      r_c           <= w_c;
      r_bitlen      <= w_bitlen;
      r_first_flag  <= w_first_flag;
      r_buf         <= w_buf;
      r_block_valid <= w_block_valid;
      r_block_first <= w_block_first;
      r_block_last  <= w_block_last;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Testbench for sha256_padder. The stimulus side pushes expected blocks into a
// scoreboard queue. A monitor pops and compares each block on its handshake.
// Random messages are checked against a padding model built on byte queues.
module tb_sha256_padder;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_empty;
  logic [511:0] M_out;
  logic         block_valid;
  logic         block_ready;
  logic         block_first;
  logic         block_last;

  int   n_tests;
  int   n_fail;
  int   rdy_mode;   // 0: always ready, 1: random, 2: driven by main sequence
  exp_t sb[$];

  sha256_padder #(.LEN_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_empty(in_empty),
    .M_out(M_out), .block_valid(block_valid), .block_ready(block_ready),
    .block_first(block_first), .block_last(block_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Padding model: message, 0x80, zeros up to 56 mod 64, then the 64-bit length.
  task automatic model_push(input bq_t msg);
    bq_t         p;
    logic [63:0] len;
    exp_t        e;
    int          nb;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.data = 512'd0;
      for (int k = 0; k < 64; k++) e.data[511-8*k -: 8] = p[64*b+k];
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      sb.push_back(e);
    end
  endtask

  task automatic push_exp(input logic [511:0] d, input logic f, input logic l);
    exp_t e;
    e.data = d; e.first = f; e.last = l;
    sb.push_back(e);
  endtask

  // Called just after a negedge. The beat is taken at the next posedge where in_ready is high.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int   budget;
    logic acc;
    in_valid = 1'b1; in_data = d; in_last = last; in_empty = empty;
    budget = 0; acc = 1'b0;
    while (!acc && budget < 2000) begin
      acc = in_ready;
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL beat_timeout: in_ready stayed %0b, required 1", in_ready);
    end
  endtask

  task automatic send_msg(input bq_t msg, input bit tail_empty, input bit gaps);
    if (msg.size() == 0) begin
      send_beat(8'($urandom), 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < msg.size(); i++) begin
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat(msg[i], (i == msg.size() - 1) && !tail_empty, 1'b0);
      end
      if (tail_empty) send_beat(8'($urandom), 1'b1, 1'b1);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || block_valid) && b < 3000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 3000) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d blocks outstanding, required 0", sb.size());
    end
  endtask

  function automatic bq_t str_bytes(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Downstream ready generator.
  initial begin
    block_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       block_ready = 1'b1;
        1:       block_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Monitor: compare each accepted block against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && block_valid && block_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_block: got %0h, no block expected", M_out);
        end else begin
          e = sb.pop_front();
          chk("block_data", M_out, e.data);
          chk("block_first", {511'd0, block_first}, {511'd0, e.first});
          chk("block_last", {511'd0, block_last}, {511'd0, e.last});
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [511:0] abc_blk;
  logic [511:0] cap;
  bq_t          m;

  initial begin
    n_tests = 0; n_fail = 0; rdy_mode = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_empty = 1'b0;
    abc_blk = {24'h616263, 8'h80, 416'd0, 64'h18};

    // Reset state.
    repeat (3) @(negedge clk);
    #1 chk("in_ready_in_reset", {511'd0, in_ready}, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_M_out", M_out, 512'd0);
    chk("rst_block_valid", {511'd0, block_valid}, 512'd0);
    chk("rst_block_first", {511'd0, block_first}, 512'd0);
    chk("rst_block_last", {511'd0, block_last}, 512'd0);
    chk("rst_in_ready", {511'd0, in_ready}, 512'd1);
    @(negedge clk);

    // "abc": the block must be valid one cycle after the last beat.
    push_exp(abc_blk, 1'b1, 1'b1);
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
    #1 chk("abc_latency_valid", {511'd0, block_valid}, 512'd1);
    @(negedge clk);
    drain();

    // Empty message.
    push_exp({8'h80, 504'd0}, 1'b1, 1'b1);
    m = {};
    send_msg(m, 1'b0, 1'b0);
    drain();

    // 56-byte two-block vector.
    m = str_bytes("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    push_exp({m[0], m[1], m[2], m[3], 416'd0, 8'h80, 56'd0}, 1'b1, 1'b0);
    sb.delete();
    model_push(m);
    chk("vec56_model_A_head", {480'd0, sb[0].data[511:480]}, {480'd0, 32'h61626364});
    chk("vec56_model_B_len", sb[1].data, {448'd0, 64'h1C0});
    send_msg(m, 1'b0, 1'b0);
    drain();

    // 64 zero bytes.
    push_exp(512'd0, 1'b1, 1'b0);
    push_exp({8'h80, 440'd0, 64'h200}, 1'b0, 1'b1);
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'h00);
    send_msg(m, 1'b0, 1'b0);
    drain();

    // Backpressure: block must hold for 10 cycles with in_ready low.
    rdy_mode = 2;
    @(negedge clk);
    block_ready = 1'b0;
    push_exp(abc_blk, 1'b1, 1'b1);
    send_msg(str_bytes("abc"), 1'b0, 1'b0);
    #1 cap = M_out;
    chk("bp_captured", cap, abc_blk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid_hold", {511'd0, block_valid}, 512'd1);
      chk("bp_in_ready_low", {511'd0, in_ready}, 512'd0);
      chk("bp_M_out_stable", M_out, cap);
    end
    @(negedge clk);
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    #1;
    chk("bp_valid_drop", {511'd0, block_valid}, 512'd0);
    chk("bp_in_ready_back", {511'd0, in_ready}, 512'd1);
    @(negedge clk);

    // Reset while a block is presented discards it.
    send_msg(str_bytes("xyz"), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_discard_valid", {511'd0, block_valid}, 512'd0);
    @(negedge clk);
    rdy_mode = 0;

    // Reset mid-message, then "abc" must look like a fresh message.
    for (int i = 0; i < 10; i++) send_beat(8'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    #1 chk("mid_rst_in_ready", {511'd0, in_ready}, 512'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rst_M_out", M_out, 512'd0);
    @(negedge clk);
    push_exp(abc_blk, 1'b1, 1'b1);
    send_msg(str_bytes("abc"), 1'b0, 1'b0);
    drain();

    // Random messages with random gaps, tails and backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int  len;
      bit  tail;
      len  = $urandom_range(0, 140);
      tail = (len > 0) && ($urandom_range(0, 3) == 0);
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      model_push(m);
      send_msg(m, tail, 1'b1);
    end
    drain();
    chk("scoreboard_empty", 512'(sb.size()), 512'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
